// File: rtl/cm_accum_dump.sv
// cm_accum_dump: accumulate-and-dump stage on the complex multiplier output.
// Sums ACC_LEN accepted 17-bit signed I/Q products per frame. Each frame sum
// is rounded half up, arithmetically shifted right by SHIFT and saturated to
// 12-bit signed. The result is presented for exactly one cycle.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   CM_en      - product valid
//   CM_out_i/q - signed 17-bit product, I/Q
//   sync_clr   - frame restart, drops any partial sum
//   acc_en     - one-cycle pulse per completed frame
//   acc_out_i/q- signed 12-bit frame result (0 when acc_en is low)
//   sat_i/q    - component was clipped (0 when acc_en is low)
//   sat_cnt    - number of clipped dumps, sticks at 0xFFFF
module cm_accum_dump #(
    parameter int unsigned ACC_LEN = 8,
    parameter int unsigned SHIFT   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               CM_en,
    input  logic signed [16:0] CM_out_i,
    input  logic signed [16:0] CM_out_q,
    input  logic               sync_clr,
    output logic               acc_en,
    output logic signed [11:0] acc_out_i,
    output logic signed [11:0] acc_out_q,
    output logic               sat_i,
    output logic               sat_q,
    output logic        [15:0] sat_cnt
);

    if (ACC_LEN == 0 || ACC_LEN > 256 || SHIFT > 13) begin : g_param_err
        $error("cm_accum_dump: ACC_LEN must be 1..256 and SHIFT 0..13");
    end

    localparam logic [7:0] LastCnt = 8'(ACC_LEN - 1);
    // Half an output LSB; zero when no shift is applied.
    localparam logic signed [25:0] RndAdd = (SHIFT == 0) ? 26'sd0 : (26'sd1 <<< (SHIFT - 1));

    logic        [7:0]  cnt_q, cnt_d, cnt_eff;
    logic signed [24:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [24:0] sum_i, sum_q;
    logic signed [24:0] dmp_i_q, dmp_i_d, dmp_q_q, dmp_q_d;
    logic               pend_q, pend_d;
    logic               acc_en_q, acc_en_d;
    logic signed [11:0] out_i_q, out_i_d, out_q_q, out_q_d;
    logic               sat_i_q, sat_i_d, sat_q_q, sat_q_d;
    logic        [15:0] sat_cnt_q, sat_cnt_d;
    logic        [12:0] rs_i, rs_q;

    // Returns {clipped, result}: round half up, shift, clip to 12-bit signed.
    function automatic logic [12:0] round_sat(input logic signed [24:0] v);
        logic signed [25:0] r;
        logic signed [25:0] s;
        r = $signed({v[24], v}) + RndAdd;
        s = r >>> SHIFT;
        if (s > 26'sd2047) begin
            return {1'b1, 12'h7FF};
        end else if (s < -26'sd2048) begin
            return {1'b1, 12'h800};
        end else begin
            return {1'b0, s[11:0]};
        end
    endfunction

    always_comb begin
        // sync_clr makes a same-cycle sample the first of a new frame.
        cnt_eff = sync_clr ? 8'd0 : cnt_q;
        sum_i   = ((cnt_eff == 8'd0) ? 25'sd0 : acc_i_q) + $signed({{8{CM_out_i[16]}}, CM_out_i});
        sum_q   = ((cnt_eff == 8'd0) ? 25'sd0 : acc_q_q) + $signed({{8{CM_out_q[16]}}, CM_out_q});

        cnt_d   = cnt_eff;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        dmp_i_d = dmp_i_q;
        dmp_q_d = dmp_q_q;
        pend_d  = 1'b0;

        if (CM_en) begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            if (cnt_eff == LastCnt) begin
                dmp_i_d = sum_i;
                dmp_q_d = sum_q;
                pend_d  = 1'b1;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_eff + 8'd1;
            end
        end

        rs_i     = round_sat(dmp_i_q);
        rs_q     = round_sat(dmp_q_q);
        acc_en_d = pend_q;
        out_i_d  = pend_q ? $signed(rs_i[11:0]) : 12'sd0;
        out_q_d  = pend_q ? $signed(rs_q[11:0]) : 12'sd0;
        sat_i_d  = pend_q & rs_i[12];
        sat_q_d  = pend_q & rs_q[12];

        sat_cnt_d = sat_cnt_q;
        if (acc_en_q && (sat_i_q || sat_q_q) && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            dmp_i_q   <= '0;
            dmp_q_q   <= '0;
            pend_q    <= 1'b0;
            acc_en_q  <= 1'b0;
            out_i_q   <= '0;
            out_q_q   <= '0;
            sat_i_q   <= 1'b0;
            sat_q_q   <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            dmp_i_q   <= dmp_i_d;
            dmp_q_q   <= dmp_q_d;
            pend_q    <= pend_d;
            acc_en_q  <= acc_en_d;
            out_i_q   <= out_i_d;
            out_q_q   <= out_q_d;
            sat_i_q   <= sat_i_d;
            sat_q_q   <= sat_q_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign acc_en    = acc_en_q;
    assign acc_out_i = out_i_q;
    assign acc_out_q = out_q_q;
    assign sat_i     = sat_i_q;
    assign sat_q     = sat_q_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_cm_accum_dump.sv
// Bench for cm_accum_dump: two instances (ACC_LEN=4/SHIFT=2 and ACC_LEN=1/SHIFT=0)
// share one stimulus stream and are compared every cycle against a frame-level
// reference model (list of expected dumps with the edge at which each appears).
module tb_cm_accum_dump;

    localparam int unsigned LenA = 4;
    localparam int unsigned ShA  = 2;
    localparam int unsigned LenB = 1;
    localparam int unsigned ShB  = 0;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cm_en = 1'b0;
    logic               sync_clr = 1'b0;
    logic signed [16:0] prod_i = '0;
    logic signed [16:0] prod_q = '0;

    logic               a_en, b_en, a_si, a_sq, b_si, b_sq;
    logic signed [11:0] a_oi, a_oq, b_oi, b_oq;
    logic        [15:0] a_sc, b_sc;

    always #5 clk = ~clk;

    cm_accum_dump #(.ACC_LEN(LenA), .SHIFT(ShA)) u_dut_a (
        .clk(clk), .rst(rst), .CM_en(cm_en), .CM_out_i(prod_i), .CM_out_q(prod_q),
        .sync_clr(sync_clr), .acc_en(a_en), .acc_out_i(a_oi), .acc_out_q(a_oq),
        .sat_i(a_si), .sat_q(a_sq), .sat_cnt(a_sc)
    );

    cm_accum_dump #(.ACC_LEN(LenB), .SHIFT(ShB)) u_dut_b (
        .clk(clk), .rst(rst), .CM_en(cm_en), .CM_out_i(prod_i), .CM_out_q(prod_q),
        .sync_clr(sync_clr), .acc_en(b_en), .acc_out_i(b_oi), .acc_out_q(b_oq),
        .sat_i(b_si), .sat_q(b_sq), .sat_cnt(b_sc)
    );

    typedef struct {
        int     due;
        longint oi;
        longint oq;
        bit     si;
        bit     sq;
    } exp_t;

    exp_t   exp_q[2][$];
    int     frm_n[2];
    longint frm_i[2];
    longint frm_q[2];
    int     sat_m[2];
    int     cyc = 0;
    bit     rst_last = 1'b0;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int len_of(input int m);
        return (m == 0) ? int'(LenA) : int'(LenB);
    endfunction

    function automatic int sh_of(input int m);
        return (m == 0) ? int'(ShA) : int'(ShB);
    endfunction

    // floor((sum + half) / 2^sh), then clip to 12-bit signed.
    function automatic void scale(input longint sum, input int sh,
                                  output longint o, output bit sat);
        longint d, r, q;
        d = longint'(1) << sh;
        r = sum + ((sh == 0) ? 0 : d / 2);
        q = r / d;
        if ((r % d) != 0 && r < 0) q = q - 1;
        sat = 1'b0;
        o   = q;
        if (q > 2047) begin
            o = 2047; sat = 1'b1;
        end else if (q < -2048) begin
            o = -2048; sat = 1'b1;
        end
    endfunction

    // Model what the edge numbered k does with the inputs now applied.
    task automatic model(input int k, input bit en, input longint vi, input longint vq,
                         input bit clr, input bit r);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                frm_n[m] = 0; frm_i[m] = 0; frm_q[m] = 0;
                exp_q[m].delete();
            end else begin
                if (clr) begin
                    frm_n[m] = 0; frm_i[m] = 0; frm_q[m] = 0;
                end
                if (en) begin
                    frm_i[m] += vi;
                    frm_q[m] += vq;
                    frm_n[m]++;
                    if (frm_n[m] == len_of(m)) begin
                        exp_t e;
                        e.due = k + 1;
                        scale(frm_i[m], sh_of(m), e.oi, e.si);
                        scale(frm_q[m], sh_of(m), e.oq, e.sq);
                        exp_q[m].push_back(e);
                        frm_n[m] = 0; frm_i[m] = 0; frm_q[m] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int m, input string nm, input logic en,
                              input logic signed [11:0] oi, input logic signed [11:0] oq,
                              input logic si, input logic sq, input logic [15:0] sc);
        exp_t e;
        bit   has;
        e   = '{due: 0, oi: 0, oq: 0, si: 1'b0, sq: 1'b0};
        has = 1'b0;
        if (exp_q[m].size() > 0 && exp_q[m][0].due == cyc) begin
            e   = exp_q[m].pop_front();
            has = 1'b1;
        end
        if (rst_last) sat_m[m] = 0;
        check_eq({nm, ".acc_en"}, en, has);
        check_eq({nm, ".acc_out_i"}, oi, e.oi);
        check_eq({nm, ".acc_out_q"}, oq, e.oq);
        check_eq({nm, ".sat_i"}, si, e.si);
        check_eq({nm, ".sat_q"}, sq, e.sq);
        check_eq({nm, ".sat_cnt"}, sc, sat_m[m]);
        if (has && (e.si || e.sq) && sat_m[m] < 65535) sat_m[m]++;
    endtask

    task automatic step(input bit en, input longint vi, input longint vq,
                        input bit clr, input bit r);
        logic [63:0] ti, tq;
        ti       = vi;
        tq       = vq;
        cm_en    = en;
        prod_i   = ti[16:0];
        prod_q   = tq[16:0];
        sync_clr = clr;
        rst      = r;
        model(cyc + 1, en, vi, vq, clr, r);
        @(posedge clk);
        cyc++;
        #1;
        rst_last = r;
        check_inst(0, "a", a_en, a_oi, a_oq, a_si, a_sq, a_sc);
        check_inst(1, "b", b_en, b_oi, b_oq, b_si, b_sq, b_sc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    function automatic longint rand_prod();
        int mode;
        mode = $urandom_range(0, 5);
        if (mode == 0) return longint'($urandom_range(0, 131071)) - 65536;
        if (mode == 1) return 65535;
        if (mode == 2) return -65536;
        return longint'($urandom_range(0, 4000)) - 2000;
    endfunction

    initial begin
        for (int m = 0; m < 2; m++) begin
            frm_n[m] = 0; frm_i[m] = 0; frm_q[m] = 0; sat_m[m] = 0;
        end

        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);

        // Rounding, positive: 5+1 -> (6+2)>>2 = 2.
        step(1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 5, 0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 1'b0, 1'b0);
        idle(3);

        // Rounding, negative, with a gap.
        step(1'b1, 0, -3, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 0, -2, 1'b0, 1'b0);
        step(1'b1, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 1'b0, 1'b0);
        idle(3);

        // Saturation on both components.
        for (int i = 0; i < 4; i++) step(1'b1, 65535, -65536, 1'b0, 1'b0);
        idle(3);

        // Back-to-back frames.
        for (int i = 0; i < 12; i++) step(1'b1, 100, -100, 1'b0, 1'b0);
        idle(3);

        // sync_clr mid-frame with a same-cycle sample.
        step(1'b1, 7, 7, 1'b0, 1'b0);
        step(1'b1, 7, 7, 1'b0, 1'b0);
        step(1'b1, 1, 1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1, 1, 1'b0, 1'b0);
        idle(3);

        // Reset mid-frame, then a clean frame; also a dump pending across reset.
        for (int i = 0; i < 3; i++) step(1'b1, 50, 50, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 10, -10, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) step(1'b1, 65535, 3, 1'b0, 1'b0);
        step(1'b1, 9, 9, 1'b0, 1'b1);
        idle(3);

        // Randomized traffic with gaps, restarts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, rand_prod(), rand_prod(),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cm_accum_dump.md
# cm_accum_dump

Accumulate-and-dump stage on the output side of the complex multiplier. It consumes the multiplier's 17-bit signed I/Q product stream, qualified by `CM_en`, and sums a programmable number of products per frame. It then rounds, scales and saturates each frame sum back to the 12-bit signed sample format used at the multiplier input. It sits between the complex multiplier and the downstream 12-bit sample path, such as the combiner output or the next filter stage.

## Interface
- `ACC_LEN`, default 8: products per dump; legal range 1..256.
- `SHIFT`, default 3: arithmetic right shift applied to the frame sum before saturation; legal range 0..13.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `CM_en` input 1: product valid; one product accepted per cycle while high.
- `CM_out_i` input 17: signed product, I component.
- `CM_out_q` input 17: signed product, Q component.
- `sync_clr` input 1: frame restart; discards any partial accumulation.
- `acc_en` output 1: one-cycle pulse per completed frame.
- `acc_out_i` output 12: signed rounded/saturated frame sum, I.
- `acc_out_q` output 12: signed rounded/saturated frame sum, Q.
- `sat_i` output 1: `acc_out_i` was clipped, qualified by `acc_en`.
- `sat_q` output 1: `acc_out_q` was clipped, qualified by `acc_en`.
- `sat_cnt` output 16: count of dumps with `sat_i` or `sat_q` set; sticks at 0xFFFF.

## Operation
- **Accumulators.** Two 25-bit signed accumulators (17 + log2(256)), `acc_i` and `acc_q`, plus an 8-bit sample counter `cnt` running 0..ACC_LEN-1.
- **Sample accepted** (`CM_en`=1 at an edge):
  - If `cnt`=0, the accumulator loads the sign-extended product. Otherwise the product is added to the accumulator.
  - `cnt` increments.
- **Last sample of a frame** (`cnt`=ACC_LEN-1 when the sample is accepted):
  - The complete sum (accumulator + product) is written to 25-bit dump registers `dmp_i`/`dmp_q`.
  - A dump-pending flag is set and `cnt` returns to 0.
  - The next frame may start on the very next cycle; no bubble is required.
- **Gaps.** `CM_en`=0 holds the accumulators and `cnt`. Gaps of any length inside a frame are legal.
- **`ACC_LEN`=1.** Every accepted sample dumps directly.
- **Output stage**, one cycle after a dump:
  - Round half up: r = dmp + 2^(SHIFT-1). For SHIFT=0 no rounding is applied. Computed at 26 bits so it cannot overflow.
  - Scale: s = r >>> SHIFT (arithmetic shift).
  - Saturate to [-2048, 2047]. Clipping sets `sat_i`/`sat_q` for that component.
- **When `acc_en`=0:** `acc_out_i`, `acc_out_q`, `sat_i` and `sat_q` are driven to 0.
- **`sat_cnt`:** increments on each `acc_en` cycle with `sat_i` | `sat_q` set, and saturates at 0xFFFF. Cleared only by `rst`.
- **`sync_clr`:**
  - Forces `cnt` to 0, discarding the partial sum.
  - If `CM_en` is high in the same cycle, that sample becomes sample 0 of the new frame. If ACC_LEN=1, that sample dumps.
  - A dump already captured in `dmp_*` still emits normally.
- **Parameter checks.** Out-of-range `ACC_LEN`/`SHIFT` are rejected by an elaboration-time check; behaviour for them is not specified.

## Timing
- **Reset.** `rst` high at an edge clears `cnt`, both accumulators, the dump registers, the dump-pending flag, `acc_en`, `acc_out_i`, `acc_out_q`, `sat_i`, `sat_q` and `sat_cnt` to 0.
  - Reset mid-frame discards the partial frame and any pending dump; no `acc_en` follows.
- **Latency.** Last sample accepted at edge k → `dmp_*` valid after edge k → `acc_en` and outputs valid after edge k+1, for one cycle.
- **Throughput.** One product per cycle sustained; with ACC_LEN=1, `acc_en` may be high every cycle.
- **Cascade with the multiplier.** With products arriving 3 cycles after `in_en` at the multiplier, frame output appears 5 cycles after the last `in_en`.

## Test plan
- **Rounding, positive.** ACC_LEN=2, SHIFT=2; I products 5, 1 on consecutive cycles → 2 cycles after the second: `acc_en`=1, `acc_out_i`=2, `sat_i`=0.
- **Rounding, negative, with gaps.** ACC_LEN=2, SHIFT=2; Q products -3, -2 with a 3-cycle `CM_en` gap between them → `acc_out_q`=-1.
- **Saturation.** ACC_LEN=4, SHIFT=2; I = +65535 ×4 and Q = -65536 ×4 → `acc_out_i`=2047, `acc_out_q`=-2048, `sat_i`=`sat_q`=1, `sat_cnt`=1.
- **Back-to-back frames.** ACC_LEN=4, SHIFT=0; 12 consecutive products of I=100 → three `acc_en` pulses, 4 cycles apart, each with `acc_out_i`=400.
- **`sync_clr` mid-frame.** ACC_LEN=4, SHIFT=0; products 7, 7, then `sync_clr`+`CM_en` with 1, then 1, 1, 1 → a single `acc_en` with `acc_out_i`=4.
- **Reset mid-frame.** ACC_LEN=4; feed 3 products, assert `rst` for 1 cycle, then feed 4 products of I=10 → no output before the reset; exactly one `acc_en` with `acc_out_i`=40>>>SHIFT (rounded); all outputs 0 during reset.
